usb_rx_decoder: RTL

Receive-side bit decoder for the USB full-speed front end. It sits directly downstream of `USB_timer_rx`: on every `shift_enable` strobe from the timer it samples the synchronized D+ level, NRZI-decodes it, removes stuffed bits, validates the SYNC field, and assembles LSB-first bytes for the packet layer. Stuffing violations and bad SYNC patterns are flagged here; the packet layer sees only clean bytes.

---
 rtl/usb_rx_decoder_if.sv | 36 +++
 rtl/usb_rx_decoder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/usb_rx_decoder_if.sv
// rtl/usb_rx_decoder_if.sv - line-side inputs and byte-side pulses of the USB receive decoder

interface usb_rx_decoder_if;
    logic       receiving;
    logic       shift_enable;
    logic       d_plus_sync;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       sync_ok;
    logic       stuff_error;
    logic       sync_error;

    // front end / timer side: drives the line samples, observes decoded bytes
    modport master (
        output receiving,
        output shift_enable,
        output d_plus_sync,
        input  rx_data,
        input  rx_valid,
        input  sync_ok,
        input  stuff_error,
        input  sync_error
    );

    // decoder side
    modport slave (
        input  receiving,
        input  shift_enable,
        input  d_plus_sync,
        output rx_data,
        output rx_valid,
        output sync_ok,
        output stuff_error,
        output sync_error
    );
endinterface

// File: rtl/usb_rx_decoder.sv
// rtl/usb_rx_decoder.sv - NRZI decode, destuff, SYNC check and byte assembly for USB full-speed receive

module usb_rx_decoder (
    input  logic            clk,
    input  logic            rst,
    usb_rx_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_DATA  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t     state;
    state_t     state_n;

    logic       prev_level;
    logic       prev_level_n;
    logic [2:0] ones_cnt;
    logic [2:0] ones_cnt_n;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_n;
    // Only seven bits are kept: the eighth accepted bit goes straight into
    // the completed byte, so the register never needs a slot for it.
    logic [6:0] shift_reg;
    logic [6:0] shift_reg_n;
    logic [7:0] rx_data_n;
    logic       rx_valid_n;
    logic       sync_ok_n;
    logic       stuff_error_n;
    logic       sync_error_n;

    logic       decoded;
    logic [7:0] byte_done;

    // NRZI: an unchanged level is a 1, a transition is a 0
    assign decoded   = (bus.d_plus_sync == prev_level);
    assign byte_done = {decoded, shift_reg};

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // next-state, datapath and pulse decode
    always_comb begin
        state_n       = state;
        prev_level_n  = prev_level;
        ones_cnt_n    = ones_cnt;
        bit_cnt_n     = bit_cnt;
        shift_reg_n   = shift_reg;
        rx_data_n     = bus.rx_data;
        rx_valid_n    = 1'b0;
        sync_ok_n     = 1'b0;
        stuff_error_n = 1'b0;
        sync_error_n  = 1'b0;

        if (!bus.receiving) begin
            // end of packet or abort: any partial byte is dropped silently
            state_n      = S_IDLE;
            prev_level_n = 1'b1;
            ones_cnt_n   = 3'd0;
            bit_cnt_n    = 3'd0;
            shift_reg_n  = 7'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    // the line idles in J, which is the NRZI reference for the first SYNC bit
                    state_n      = S_SYNC;
                    prev_level_n = 1'b1;
                    ones_cnt_n   = 3'd0;
                    bit_cnt_n    = 3'd0;
                    shift_reg_n  = 7'd0;
                end
                S_SYNC, S_DATA: begin
                    if (bus.shift_enable) begin
                        prev_level_n = bus.d_plus_sync;
                        if (ones_cnt == 3'd6) begin
                            // this sample is the stuff bit: a 0 is discarded, a 1 is a violation
                            if (decoded) begin
                                stuff_error_n = 1'b1;
                                state_n       = S_ERROR;
                            end else begin
                                ones_cnt_n = 3'd0;
                            end
                        end else begin
                            ones_cnt_n  = decoded ? (ones_cnt + 3'd1) : 3'd0;
                            shift_reg_n = byte_done[7:1];
                            bit_cnt_n   = bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (state == S_SYNC) begin
                                    if (byte_done == 8'h80) begin
                                        sync_ok_n = 1'b1;
                                        state_n   = S_DATA;
                                    end else begin
                                        sync_error_n = 1'b1;
                                        state_n      = S_ERROR;
                                    end
                                end else begin
                                    rx_valid_n = 1'b1;
                                    rx_data_n  = byte_done;
                                end
                            end
                        end
                    end
                end
                default: begin
                    // S_ERROR: wait for receiving to drop
                end
            endcase
        end
    end

    // datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_level      <= 1'b1;
            ones_cnt        <= 3'd0;
            bit_cnt         <= 3'd0;
            shift_reg       <= 7'd0;
            bus.rx_data     <= 8'h00;
            bus.rx_valid    <= 1'b0;
            bus.sync_ok     <= 1'b0;
            bus.stuff_error <= 1'b0;
            bus.sync_error  <= 1'b0;
        end else begin
            prev_level      <= prev_level_n;
            ones_cnt        <= ones_cnt_n;
            bit_cnt         <= bit_cnt_n;
            shift_reg       <= shift_reg_n;
            bus.rx_data     <= rx_data_n;
            bus.rx_valid    <= rx_valid_n;
            bus.sync_ok     <= sync_ok_n;
            bus.stuff_error <= stuff_error_n;
            bus.sync_error  <= sync_error_n;
        end
    end

endmodule
